// File: rtl/scan_mux_ctrl.sv
// N-channel registered data mux with a round-robin dwell sequencer (auto mode)
// or an external select (manual mode). One cycle from cur_sel/din to dout.
//
// state | meaning
// IDLE  | no dwell in progress; resting state in manual mode or when no channel is enabled
// DWELL | showing cur_sel while cnt counts up to the latched dwell value
module scan_mux_ctrl #(
    parameter  int NCH     = 4,
    parameter  int W       = 8,
    parameter  int DWELL_W = 8,
    localparam int SEL_W   = $clog2(NCH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NCH*W-1:0]   din,
    input  logic               mode,
    input  logic [SEL_W-1:0]   man_sel,
    input  logic [NCH-1:0]     en_mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               hold,
    output logic [W-1:0]       dout,
    output logic [SEL_W-1:0]   out_sel,
    output logic               sel_valid,
    output logic               adv_pulse
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_DWELL = 1'b1;

    localparam logic [SEL_W:0] NCH_L = (SEL_W + 1)'(NCH);

    logic [W-1:0]       ch [NCH];
    logic [0:0]         state, state_d;
    logic [SEL_W-1:0]   cur_sel, sel_d;
    logic [DWELL_W-1:0] cnt, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               adv_d;
    logic               man_ok, cur_ok, valid_d;
    logic [W-1:0]       dout_d;

    for (genvar k = 0; k < NCH; k++) begin : g_slice
        assign ch[k] = din[k*W +: W];
    end

    // First enabled channel at or above start, wrapping to the lowest enabled one.
    function automatic logic [SEL_W-1:0] next_en(input logic [NCH-1:0] mask, input int start);
        logic [SEL_W-1:0] lo;
        logic [SEL_W-1:0] hi;
        logic             hit;
        lo  = '0;
        hi  = '0;
        hit = 1'b0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (mask[k]) begin
                lo = SEL_W'(k);
                if (k >= start) begin
                    hi  = SEL_W'(k);
                    hit = 1'b1;
                end
            end
        end
        return hit ? hi : lo;
    endfunction

    always_comb begin
        state_d = state;
        sel_d   = cur_sel;
        cnt_d   = cnt;
        dwell_d = dwell_q;
        adv_d   = 1'b0;
        man_ok  = ({1'b0, man_sel} < NCH_L);
        cur_ok  = ({1'b0, cur_sel} < NCH_L);

        if (!mode) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            if (man_ok) begin
                sel_d = man_sel;
            end
        end else if (state == S_IDLE) begin
            if (|en_mask) begin
                state_d = S_DWELL;
                sel_d   = next_en(en_mask, int'(cur_sel));
                cnt_d   = '0;
                dwell_d = dwell;
                adv_d   = 1'b1;
            end
        end else if (en_mask == '0) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (!en_mask[cur_sel] || (!hold && (cnt == dwell_q))) begin
            // A disabled current channel forces an advance even while held.
            sel_d   = next_en(en_mask, int'(cur_sel) + 1);
            cnt_d   = '0;
            dwell_d = dwell;
            adv_d   = 1'b1;
        end else if (!hold) begin
            cnt_d = cnt + DWELL_W'(1);
        end

        valid_d = cur_ok && (mode ? en_mask[cur_sel] : man_ok);
        dout_d  = valid_d ? ch[cur_sel] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cur_sel   <= '0;
            cnt       <= '0;
            dwell_q   <= '0;
            dout      <= '0;
            out_sel   <= '0;
            sel_valid <= 1'b0;
            adv_pulse <= 1'b0;
        end else begin
            state     <= state_d;
            cur_sel   <= sel_d;
            cnt       <= cnt_d;
            dwell_q   <= dwell_d;
            dout      <= dout_d;
            out_sel   <= cur_sel;
            sel_valid <= valid_d;
            adv_pulse <= adv_d;
        end
    end

endmodule

// File: tb/tb_scan_mux_ctrl.sv
// Directed bench for scan_mux_ctrl: stimulus pushes expected output snapshots
// tagged with the cycle they belong to; a monitor pops and compares at negedge.
module tb_scan_mux_ctrl;

    typedef struct {
        int          cyc;
        bit          b;
        string       name;
        logic [7:0]  d;
        logic [1:0]  s;
        logic        v;
        logic        a;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] din;
    logic        mode;
    logic [1:0]  man_sel;
    logic [3:0]  en_mask;
    logic [7:0]  dwell;
    logic        hold;
    logic [7:0]  dout;
    logic [1:0]  out_sel;
    logic        sel_valid;
    logic        adv_pulse;

    logic [23:0] din_b;
    logic        mode_b;
    logic [1:0]  man_sel_b;
    logic [2:0]  en_mask_b;
    logic [7:0]  dout_b;
    logic [1:0]  out_sel_b;
    logic        sel_valid_b;
    logic        adv_pulse_b;

    exp_t sb[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    int         scan_sel [14] = '{0, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    logic       scan_adv [14] = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
    logic [7:0] dv [4]        = '{8'h11, 8'h22, 8'h33, 8'h44};

    scan_mux_ctrl #(.NCH(4), .W(8), .DWELL_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .mode(mode), .man_sel(man_sel),
        .en_mask(en_mask), .dwell(dwell), .hold(hold), .dout(dout),
        .out_sel(out_sel), .sel_valid(sel_valid), .adv_pulse(adv_pulse)
    );

    scan_mux_ctrl #(.NCH(3), .W(8), .DWELL_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din_b), .mode(mode_b), .man_sel(man_sel_b),
        .en_mask(en_mask_b), .dwell(dwell), .hold(hold), .dout(dout_b),
        .out_sel(out_sel_b), .sel_valid(sel_valid_b), .adv_pulse(adv_pulse_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input bit b, input string nm, input logic [7:0] d,
                        input logic [1:0] s, input logic v, input logic a);
        exp_t e;
        e.cyc = c; e.b = b; e.name = nm; e.d = d; e.s = s; e.v = v; e.a = a;
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [7:0] d, input logic [1:0] s,
                       input logic v, input logic a);
        push(cyc + 1, 1'b0, nm, d, s, v, a);
        step();
    endtask

    task automatic chkb(input string nm, input logic [7:0] d, input logic [1:0] s,
                        input logic v, input logic a);
        push(cyc + 1, 1'b1, nm, d, s, v, a);
        step();
    endtask

    // Monitor: compare every expectation due at this cycle.
    initial begin
        exp_t       e;
        logic [7:0] ad;
        logic [1:0] as;
        logic       av, aa;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                ad = e.b ? dout_b      : dout;
                as = e.b ? out_sel_b   : out_sel;
                av = e.b ? sel_valid_b : sel_valid;
                aa = e.b ? adv_pulse_b : adv_pulse;
                checks++;
                if (e.cyc < cyc) begin
                    errors++;
                    $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
                end else if (ad !== e.d || as !== e.s || av !== e.v || aa !== e.a) begin
                    errors++;
                    $display("FAIL %s @cyc %0d: got dout=%h sel=%0d valid=%b adv=%b, want dout=%h sel=%0d valid=%b adv=%b",
                             e.name, cyc, ad, as, av, aa, e.d, e.s, e.v, e.a);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n     = 1'b0;
        din       = {8'h44, 8'h33, 8'h22, 8'h11};
        mode      = 1'b1;
        man_sel   = 2'd0;
        en_mask   = 4'b0000;
        dwell     = 8'd0;
        hold      = 1'b0;
        din_b     = {8'hC3, 8'hB2, 8'hA1};
        mode_b    = 1'b0;
        man_sel_b = 2'd0;
        en_mask_b = 3'b000;

        // reset and idle with nothing enabled
        repeat (3) chk("reset", 8'h00, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (2) chk("idle", 8'h00, 2'd0, 1'b0, 1'b0);

        // full scan, dwell=2
        en_mask = 4'b1111;
        dwell   = 8'd2;
        for (int i = 0; i < 14; i++)
            chk("scan", dv[scan_sel[i]], 2'(scan_sel[i]), 1'b1, scan_adv[i]);

        // skip disabled channels with wrap, dwell=0
        en_mask = 4'b1010;
        dwell   = 8'd0;
        chk("skip", 8'h00, 2'd0, 1'b0, 1'b1);
        chk("skip", 8'h22, 2'd1, 1'b1, 1'b1);
        chk("skip", 8'h44, 2'd3, 1'b1, 1'b1);
        chk("skip", 8'h22, 2'd1, 1'b1, 1'b1);
        chk("skip", 8'h44, 2'd3, 1'b1, 1'b1);
        chk("skip", 8'h22, 2'd1, 1'b1, 1'b1);
        en_mask = 4'b0010;
        chk("drop3", 8'h00, 2'd3, 1'b0, 1'b1);
        chk("single", 8'h22, 2'd1, 1'b1, 1'b1);

        // hold for 5 cycles at cnt=1, dwell=3
        en_mask = 4'b1111;
        dwell   = 8'd3;
        chk("hold_pre", 8'h22, 2'd1, 1'b1, 1'b1);
        chk("hold_pre", 8'h33, 2'd2, 1'b1, 1'b0);
        hold = 1'b1;
        repeat (5) chk("hold_frz", 8'h33, 2'd2, 1'b1, 1'b0);
        hold = 1'b0;
        repeat (2) chk("hold_rel", 8'h33, 2'd2, 1'b1, 1'b0);
        chk("hold_adv", 8'h33, 2'd2, 1'b1, 1'b1);
        chk("hold_next", 8'h44, 2'd3, 1'b1, 1'b0);

        // disabling the current channel advances even under hold
        hold    = 1'b1;
        en_mask = 4'b0111;
        chk("drop_hold", 8'h00, 2'd3, 1'b0, 1'b1);
        chk("drop_hold", 8'h11, 2'd0, 1'b1, 1'b0);
        hold = 1'b0;
        repeat (3) chk("count", 8'h11, 2'd0, 1'b1, 1'b0);
        // hold at terminal count wins over expiry
        hold = 1'b1;
        repeat (2) chk("hold_exp", 8'h11, 2'd0, 1'b1, 1'b0);
        hold = 1'b0;
        chk("exp_adv", 8'h11, 2'd0, 1'b1, 1'b1);
        chk("exp_next", 8'h22, 2'd1, 1'b1, 1'b0);
        repeat (2) chk("to_ch2", 8'h22, 2'd1, 1'b1, 1'b0);
        chk("to_ch2", 8'h22, 2'd1, 1'b1, 1'b1);
        chk("on_ch2", 8'h33, 2'd2, 1'b1, 1'b0);

        // auto -> manual mid-dwell, manual ignores en_mask, back to auto
        mode    = 1'b0;
        man_sel = 2'd0;
        chk("man_sw", 8'h33, 2'd2, 1'b1, 1'b0);
        chk("man_sw", 8'h11, 2'd0, 1'b1, 1'b0);
        man_sel = 2'd2;
        en_mask = 4'b0000;
        chk("man_sel2", 8'h11, 2'd0, 1'b1, 1'b0);
        chk("man_sel2", 8'h33, 2'd2, 1'b1, 1'b0);
        man_sel = 2'd0;
        en_mask = 4'b1111;
        chk("man_sel0", 8'h33, 2'd2, 1'b1, 1'b0);
        chk("man_sel0", 8'h11, 2'd0, 1'b1, 1'b0);
        mode = 1'b1;
        chk("auto_back", 8'h11, 2'd0, 1'b1, 1'b1);
        repeat (3) chk("auto_dwell", 8'h11, 2'd0, 1'b1, 1'b0);
        chk("auto_adv", 8'h11, 2'd0, 1'b1, 1'b1);
        chk("auto_ch1", 8'h22, 2'd1, 1'b1, 1'b0);

        // asynchronous reset mid-cycle, mid-dwell
        step();
        #2;
        rst_n = 1'b0;
        push(cyc, 1'b0, "async_rst", 8'h00, 2'd0, 1'b0, 1'b0);
        chk("rst_hold", 8'h00, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        chk("rst_first", 8'h11, 2'd0, 1'b1, 1'b1);
        chk("rst_first", 8'h11, 2'd0, 1'b1, 1'b0);

        // NCH=3 instance: manual select including the illegal index 3
        man_sel_b = 2'd2;
        chkb("b_man", 8'hA1, 2'd0, 1'b1, 1'b0);
        chkb("b_man", 8'hC3, 2'd2, 1'b1, 1'b0);
        man_sel_b = 2'd3;
        repeat (2) chkb("b_illegal", 8'h00, 2'd2, 1'b0, 1'b0);
        man_sel_b = 2'd1;
        chkb("b_recover", 8'hC3, 2'd2, 1'b1, 1'b0);
        chkb("b_recover", 8'hB2, 2'd1, 1'b1, 1'b0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expectations never compared", sb.size());
            errors += sb.size();
            checks += sb.size();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
